// File: rtl/swa_weight_ctrl_pkg.sv
// Shared constants and helpers for the switch-allocator weight scheduler.
package swa_weight_ctrl_pkg;

   localparam int DEF_V = 4;
   localparam int DEF_P = 5;
   localparam int PV    = DEF_P * DEF_V;

   localparam string SWA_RRA  = "RRA";
   localparam string SWA_WRRA = "WRRA";

   // Bits needed to hold a port number (never less than one bit).
   function automatic int log2(input int n);
      int r;
      r = 1;
      while ((1 << r) < n) r = r + 1;
      return r;
   endfunction

endpackage

// File: rtl/swa_weight_ctrl_weight_counter.sv
// One quantum counter: counts grants down to zero, reloads from the weight.
// The consumed flag is a flop that always mirrors "counter is zero".
module weight_counter #(
   parameter int WEIGHTw        = 4,
   parameter int DEFAULT_WEIGHT = 3
) (
   input  logic               clk,
   input  logic               reset,
   input  logic               grant,
   input  logic               idle,
   input  logic               reload,
   input  logic [WEIGHTw-1:0] weight,
   output logic [WEIGHTw-1:0] cnt,
   output logic               consumed
);

   logic [WEIGHTw-1:0] r_cnt;
   logic               r_consumed;
   logic [WEIGHTw-1:0] w_cnt_next;

   // Next count: a grant on an empty counter opens a fresh quantum already
   // charged with that grant; idle or port reload refill the full weight.
   always_comb begin
      w_cnt_next = r_cnt;
      if (grant) begin
         if (r_cnt > WEIGHTw'(1))
            w_cnt_next = r_cnt - WEIGHTw'(1);
         else if (r_cnt == WEIGHTw'(1))
            w_cnt_next = '0;
         else
            w_cnt_next = weight - WEIGHTw'(1);
      end else if (idle && (r_cnt == '0)) begin
         w_cnt_next = weight;
      end else if (reload) begin
         w_cnt_next = weight;
      end
   end

   // Counter and its zero flag update on the same edge.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         r_cnt      <= WEIGHTw'(DEFAULT_WEIGHT);
         r_consumed <= 1'b0;
      end else begin
         r_cnt      <= w_cnt_next;
         r_consumed <= (w_cnt_next == '0);
      end
   end

   assign cnt      = r_cnt;
   assign consumed = r_consumed;

endmodule

// File: rtl/swa_weight_ctrl.sv
// Per-port weight scheduler feeding the WRR switch allocator: tracks grant
// quanta per input VC and per input port and tells the arbiter when a
// requester has used its share. RRA mode bypasses everything with ones.
module swa_weight_ctrl
   import swa_weight_ctrl_pkg::*;
#(
   parameter int    V                = DEF_V,
   parameter int    P                = DEF_P,
   parameter int    WEIGHTw          = 4,
   parameter int    DEFAULT_WEIGHT   = 3,
   parameter string SWA_ARBITER_TYPE = SWA_WRRA
) (
   input  logic                 clk,
   input  logic                 reset,
   input  logic [P*V-1:0]       ivc_request_all,
   input  logic [P*V-1:0]       ivc_num_getting_sw_grant,
   input  logic                 cfg_we,
   input  logic [log2(P)-1:0]   cfg_port,
   input  logic [WEIGHTw-1:0]   cfg_weight,
   output logic [P*V-1:0]       vc_weight_is_consumed_all,
   output logic [P-1:0]         iport_weight_is_consumed_all
);

   if (SWA_ARBITER_TYPE == SWA_RRA) begin : g_rra
      // Plain round-robin: arbiter may rotate after every grant.
      assign vc_weight_is_consumed_all    = '1;
      assign iport_weight_is_consumed_all = '1;
   end else begin : g_wrra
      logic [WEIGHTw-1:0] r_weight   [P];
      logic [WEIGHTw-1:0] w_vc_cnt   [P*V];
      logic [WEIGHTw-1:0] w_port_cnt [P];

      // Weight register file; zero is promoted to one, bad port numbers dropped.
      always_ff @(posedge clk or posedge reset) begin
         if (reset) begin
            for (int p = 0; p < P; p++) r_weight[p] <= WEIGHTw'(DEFAULT_WEIGHT);
         end else if (cfg_we && (32'(cfg_port) < P)) begin
            r_weight[cfg_port] <= (cfg_weight == '0) ? WEIGHTw'(1) : cfg_weight;
         end
      end

      for (genvar gi = 0; gi < P; gi++) begin : g_port
         logic [V-1:0] w_req;
         logic [V-1:0] w_gnt;
         logic [V-1:0] w_busy;
         logic         w_port_grant;
         logic         w_port_idle;
         logic         w_reload;

         assign w_req = ivc_request_all[gi*V +: V];
         assign w_gnt = ivc_num_getting_sw_grant[gi*V +: V];

         for (genvar gj = 0; gj < V; gj++) begin : g_vc
            // A VC still holding quantum while requesting blocks the refill.
            assign w_busy[gj] = w_req[gj] && (w_vc_cnt[gi*V+gj] != '0);

            weight_counter #(
               .WEIGHTw        (WEIGHTw),
               .DEFAULT_WEIGHT (DEFAULT_WEIGHT)
            ) u_vc_cnt (
               .clk      (clk),
               .reset    (reset),
               .grant    (w_gnt[gj]),
               .idle     (!w_req[gj]),
               .reload   (w_reload),
               .weight   (r_weight[gi]),
               .cnt      (w_vc_cnt[gi*V+gj]),
               .consumed (vc_weight_is_consumed_all[gi*V+gj])
            );
         end

         // Refill the whole port once every requester has run dry and nobody won.
         assign w_port_grant = |w_gnt;
         assign w_port_idle  = ~|w_req;
         assign w_reload     = !w_port_grant && !(|w_busy) && !w_port_idle;

         weight_counter #(
            .WEIGHTw        (WEIGHTw),
            .DEFAULT_WEIGHT (DEFAULT_WEIGHT)
         ) u_port_cnt (
            .clk      (clk),
            .reset    (reset),
            .grant    (w_port_grant),
            .idle     (w_port_idle),
            .reload   (w_reload),
            .weight   (r_weight[gi]),
            .cnt      (w_port_cnt[gi]),
            .consumed (iport_weight_is_consumed_all[gi])
         );

         // The switch allocator grants at most one VC of a port per cycle.
         a_one_grant: assert property (@(posedge clk) disable iff (reset)
            $onehot0(w_gnt));

         // Port flag must agree with its counter.
         a_port_flag: assert property (@(posedge clk) disable iff (reset)
            ((w_port_cnt[gi] == '0) == iport_weight_is_consumed_all[gi]));
      end
   end

endmodule
